// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: buffers SET point-counting jobs in a small FIFO, issues
// them one at a time over the SET en/busy/valid handshake, and returns each
// candidate count with its job tag on a single-entry valid/ready result port.
// A watchdog aborts a job whose result never arrives and reports it with res_err.
module set_job_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 6,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             idle
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WD_W    = $clog2(TIMEOUT) + 1;
    localparam int ENTRY_W = 24 + 12 + 2 + TAG_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    // Each entry is {central, radius, mode, tag}; the tag is fixed at push time.
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    logic [TAG_W-1:0]   tag_cnt;
    logic [TAG_W-1:0]   cur_tag;
    logic [WD_W-1:0]    watchdog;

    logic push;
    logic pop;
    logic fifo_empty;
    logic got_result;
    logic timed_out;
    logic res_fire;

    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign fifo_empty = (count == '0);
    assign job_ready  = (count < DEPTH_C);
    assign push       = job_valid & job_ready;
    assign head       = fifo_mem[rd_ptr];
    assign res_fire   = res_valid & res_ready;
    assign idle       = fifo_empty & (state == S_IDLE) & ~res_valid;

    // Next-state and control decode; a new job is only started when the result
    // slot is empty, so a pending result can never be overwritten.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        set_en     = 1'b0;
        got_result = 1'b0;
        timed_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !set_busy && !res_valid) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                set_en     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last watchdog cycle still counts.
                if (set_valid) begin
                    got_result = 1'b1;
                    state_next = S_IDLE;
                end else if (watchdog == WD_LAST) begin
                    timed_out  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {job_central, job_radius, job_mode, tag_cnt};
        end
    end

    // FIFO pointers, fill count and the wrapping tag counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Job presented to SET, held stable from issue until the next issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            cur_tag     <= '0;
        end else if (pop) begin
            {set_central, set_radius, set_mode, cur_tag} <= head;
        end
    end

    // FSM state and the watchdog, which restarts from 0 on every WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            watchdog <= '0;
        end else begin
            state <= state_next;
            if (state != S_WAIT) begin
                watchdog <= '0;
            end else begin
                watchdog <= watchdog + 1'b1;
            end
        end
    end

    // Single-entry result slot: captured on completion or timeout, held until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
        end else if (got_result) begin
            res_valid     <= 1'b1;
            res_candidate <= set_candidate;
            res_tag       <= cur_tag;
            res_err       <= 1'b0;
        end else if (timed_out) begin
            res_valid     <= 1'b1;
            res_candidate <= '0;
            res_tag       <= cur_tag;
            res_err       <= 1'b1;
        end else if (res_fire) begin
            res_valid <= 1'b0;
        end
    end

endmodule
